// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the core and a word-wide memory port.
// Realigns byte lanes, splits word-crossing accesses and faults the high region.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      state, state_n;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q, lo_q;

  logic        accept;
  logic        src_we;
  logic [2:0]  src_size;
  logic [31:0] src_addr, src_wdata;
  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic [3:0]  byte_mask;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        split, fault;
  logic [31:0] ld_lo, ld_raw, ld_ext;

  logic        mem_req_n, done_n, err_n;
  logic [31:0] mem_addr_n, mem_wdata_n, rdata_n;
  logic [3:0]  mem_wen_n;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // In IDLE the live request drives the lane math so the first transaction
  // can be registered on the accept edge; afterwards the latched copy does.
  assign src_we    = (state == IDLE) ? req_we    : we_q;
  assign src_size  = (state == IDLE) ? req_size  : size_q;
  assign src_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign src_wdata = (state == IDLE) ? req_wdata : wdata_q;

  always_comb begin
    case (src_size[2:1])
      2'b00:   begin nbytes = 3'd1; byte_mask = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; byte_mask = 4'b0011; end
      default: begin nbytes = 3'd4; byte_mask = 4'b1111; end
    endcase
  end

  assign off    = src_addr[1:0];
  assign mask8  = {4'b0000, byte_mask} << off;
  assign data64 = {32'b0, src_wdata} << {off, 3'b000};
  assign split  = ({1'b0, off} + nbytes) > 3'd4;
  // With addr[31]=0 the second word only reaches the high region on a carry out of addr[30:2].
  assign fault  = (src_size[2:1] == 2'b11) || src_addr[31] || (split && (&src_addr[30:2]));

  assign ld_lo  = (state == ACC0) ? mem_rdata : lo_q;
  assign ld_raw = 32'({mem_rdata, ld_lo} >> {off, 3'b000});

  always_comb begin
    case (src_size[2:1])
      2'b00:   ld_ext = src_size[0] ? {24'b0, ld_raw[7:0]}  : {{24{ld_raw[7]}}, ld_raw[7:0]};
      2'b01:   ld_ext = src_size[0] ? {16'b0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)  state_n = fault ? DONE : ACC0;
      ACC0:    if (mem_ack) state_n = split ? ACC1 : DONE;
      ACC1:    if (mem_ack) state_n = DONE;
      DONE:                 state_n = IDLE;
      default:              state_n = IDLE;
    endcase
  end

  // NOTE: every output-next value is assigned a default first, so no path infers a latch.
  always_comb begin
    mem_req_n   = mem_req;
    mem_addr_n  = mem_addr;
    mem_wen_n   = mem_wen;
    mem_wdata_n = mem_wdata;
    done_n      = 1'b0;
    err_n       = 1'b0;
    rdata_n     = '0;
    case (state)
      IDLE: begin
        if (accept && fault) begin
          done_n = 1'b1;
          err_n  = 1'b1;
        end else if (accept) begin
          mem_req_n   = 1'b1;
          mem_addr_n  = {src_addr[31:2], 2'b00};
          mem_wen_n   = src_we ? mask8[3:0] : 4'b0000;
          mem_wdata_n = data64[31:0];
        end
      end
      ACC0, ACC1: begin
        if (mem_ack && state == ACC0 && split) begin
          mem_addr_n  = mem_addr + 32'd4;
          mem_wen_n   = src_we ? mask8[7:4] : 4'b0000;
          mem_wdata_n = data64[63:32];
        end else if (mem_ack) begin
          mem_req_n   = 1'b0;
          mem_addr_n  = '0;
          mem_wen_n   = 4'b0000;
          mem_wdata_n = '0;
          done_n      = 1'b1;
          rdata_n     = src_we ? 32'b0 : ld_ext;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wen   <= 4'b0000;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      mem_req   <= mem_req_n;
      mem_addr  <= mem_addr_n;
      mem_wen   <= mem_wen_n;
      mem_wdata <= mem_wdata_n;
      done      <= done_n;
      err       <= err_n;
      rdata     <= rdata_n;
    end
  end

  // NOTE: request and low-word holding registers need no reset; they are only read after being loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (state == ACC0 && mem_ack) lo_q <= mem_rdata;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: byte-level memory model plus an
// access predictor that lists expected word transactions and load results.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        done, err;
  logic [31:0] rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } res_t;

  txn_t        exp_txn[$];
  res_t        exp_res[$];
  logic [7:0]  mem_b [logic [31:0]];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wait_states = 0;
  int          wait_cnt = 0;
  bit          spurious_ack = 1'b0;
  txn_t        ct;
  logic [31:0] lanes;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem_b.exists(a) ? mem_b[a] : 8'h00;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] w);
    return {rd_byte(w + 32'd3), rd_byte(w + 32'd2), rd_byte(w + 32'd1), rd_byte(w)};
  endfunction

  task automatic set_word(input logic [31:0] w, input logic [31:0] v);
    for (int b = 0; b < 4; b++) mem_b[w + 32'(b)] = v[8*b +: 8];
  endtask

  // Walks the accessed bytes one at a time and groups them by word.
  task automatic predict(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output int nt, output txn_t t0,
                         output txn_t t1, output res_t r);
    int          n;
    logic        bad;
    logic [31:0] a, w, val;
    txn_t        cur;
    n   = (size[2:1] == 2'b00) ? 1 : (size[2:1] == 2'b01) ? 2 : 4;
    bad = (size[2:1] == 2'b11);
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (a[31]) bad = 1'b1;
    end
    nt  = 0;
    t0  = '0;
    t1  = '0;
    r   = '0;
    val = '0;
    cur = '0;
    if (bad) begin
      r.err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      w = {a[31:2], 2'b00};
      if (nt == 0 || w != cur.addr) begin
        if (nt == 1) t0 = cur;
        cur      = '0;
        cur.addr = w;
        nt++;
      end
      if (we) begin
        cur.wen[a[1:0]]            = 1'b1;
        cur.data[8*a[1:0] +: 8]    = wdata[8*i +: 8];
      end else begin
        val[8*i +: 8] = rd_byte(a);
      end
    end
    if (nt == 1) t0 = cur;
    else         t1 = cur;
    if (!we) begin
      case (n)
        1:       r.rdata = size[0] ? {24'h0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
        2:       r.rdata = size[0] ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
        default: r.rdata = val;
      endcase
    end
  endtask

  // Memory responder and output checker, both evaluated on the falling edge.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else begin
        if (mem_req) begin
          if (exp_txn.size() == 0) begin
            check("spurious_mem_req", mem_req, 1'b0);
          end else begin
            ct    = exp_txn[0];
            lanes = {{8{ct.wen[3]}}, {8{ct.wen[2]}}, {8{ct.wen[1]}}, {8{ct.wen[0]}}};
            check("mem_addr", mem_addr, ct.addr);
            check("mem_wen", 32'(mem_wen), 32'(ct.wen));
            check("mem_wdata", mem_wdata & lanes, ct.data & lanes);
          end
          if (wait_cnt >= wait_states) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_word({mem_addr[31:2], 2'b00});
            for (int b = 0; b < 4; b++)
              if (mem_wen[b]) mem_b[{mem_addr[31:2], 2'b00} + 32'(b)] = mem_wdata[8*b +: 8];
            if (exp_txn.size() > 0) exp_txn.delete(0);
            wait_cnt = 0;
          end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            wait_cnt++;
          end
        end else begin
          check("idle_mem_wen", 32'(mem_wen), 32'h0);
          mem_ack   = spurious_ack;
          mem_rdata = $urandom;
          wait_cnt  = 0;
        end
        if (done) begin
          if (exp_res.size() == 0) begin
            check("spurious_done", done, 1'b0);
          end else begin
            check("err", err, exp_res[0].err);
            check("rdata", rdata, exp_res[0].rdata);
            check("txn_count", 32'(exp_txn.size()), 32'h0);
            exp_res.delete(0);
          end
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input int exp_lat,
                        input string name);
    int   nt;
    txn_t t0, t1;
    res_t r;
    int   lat;
    bit   got;
    predict(we, size, addr, wdata, nt, t0, t1, r);
    if (nt > 0) exp_txn.push_back(t0);
    if (nt > 1) exp_txn.push_back(t1);
    exp_res.push_back(r);
    wait_states = waits;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (req_ready) got = 1'b1;
      else           @(negedge clk);
    end
    check({name, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_size  = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 40) begin
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({name, "_done_seen"}, got, 1'b1);
    if (got && exp_lat >= 0) check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    last_rdata = rdata;
    last_err   = err;
    @(negedge clk);
    check({name, "_done_pulse"}, done, 1'b0);
    check({name, "_ready_after"}, req_ready, 1'b1);
  endtask

  initial begin
    int   nt;
    txn_t t0, t1;
    res_t r;
    bit   found;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_wen", 32'(mem_wen), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);

    predict(1'b1, 3'b100, 32'h6, 32'h11223344, nt, t0, t1, r);
    check("model_split_nt", 32'(nt), 32'd2);
    check("model_t0_addr", t0.addr, 32'h4);
    check("model_t0_wen", 32'(t0.wen), 32'hC);
    check("model_t0_data", 32'(t0.data[31:16]), 32'h3344);
    check("model_t1_addr", t1.addr, 32'h8);
    check("model_t1_wen", 32'(t1.wen), 32'h3);
    check("model_t1_data", 32'(t1.data[15:0]), 32'h1122);

    do_req(1'b1, 3'b100, 32'h100, 32'hDEADBEEF, 0, 2, "st_word");
    check("st_word_mem", rd_word(32'h100), 32'hDEADBEEF);
    do_req(1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 2, "st_byte");
    check("st_byte_mem", rd_word(32'h200), 32'hA5000000);

    set_word(32'h100, 32'h80123456);
    set_word(32'h104, 32'h123456FF);
    predict(1'b0, 3'b010, 32'h103, 32'h0, nt, t0, t1, r);
    check("model_ld_half_s", r.rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'b010, 32'h103, 32'h0, 0, 3, "ld_half_s");
    check("ld_half_s_lit", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'b011, 32'h103, 32'h0, 0, 3, "ld_half_u");
    check("ld_half_u_lit", last_rdata, 32'h0000FF80);

    do_req(1'b1, 3'b100, 32'h6, 32'h11223344, 2, 7, "st_split_wait");
    check("st_split_lo_mem", rd_word(32'h4), 32'h33440000);
    check("st_split_hi_mem", rd_word(32'h8), 32'h00001122);

    do_req(1'b1, 3'b000, 32'h80000000, 32'h5A, 0, 1, "flt_high");
    check("flt_high_err", last_err, 1'b1);
    check("flt_high_rdata", last_rdata, 32'h0);
    do_req(1'b0, 3'b100, 32'h7FFFFFFE, 32'h0, 0, 1, "flt_cross");
    check("flt_cross_err", last_err, 1'b1);
    do_req(1'b0, 3'b110, 32'h10, 32'h0, 0, 1, "flt_size");
    check("flt_size_err", last_err, 1'b1);

    do_req(1'b0, 3'b000, 32'h103, 32'h0, 0, 2, "ld_byte_s");
    check("ld_byte_s_lit", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'b011, 32'h101, 32'h0, 0, 2, "ld_half_off1");
    check("ld_half_off1_lit", last_rdata, 32'h00001234);
    do_req(1'b0, 3'b101, 32'h100, 32'h0, 0, 2, "ld_word_u");
    check("ld_word_u_lit", last_rdata, 32'h80123456);
    do_req(1'b1, 3'b010, 32'h207, 32'h0000BEEF, 0, 3, "st_half_split");
    check("st_half_split_lo", 32'(rd_byte(32'h207)), 32'hEF);
    check("st_half_split_hi", 32'(rd_byte(32'h208)), 32'hBE);
    do_req(1'b0, 3'b100, 32'h7FFFFFFC, 32'h0, 0, 2, "ld_word_top");
    check("ld_word_top_err", last_err, 1'b0);

    spurious_ack = 1'b1;
    do_req(1'b0, 3'b100, 32'h104, 32'h0, 1, 3, "ld_spur_ack");
    check("ld_spur_ack_lit", last_rdata, 32'h123456FF);
    spurious_ack = 1'b0;

    // Reset while the second half of a split store is waiting for its ack.
    wait_states = 3;
    predict(1'b1, 3'b100, 32'h30A, 32'h55667788, nt, t0, t1, r);
    exp_txn.push_back(t0);
    exp_txn.push_back(t1);
    exp_res.push_back(r);
    check("rst_mid_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 3'b100;
    req_addr  = 32'h30A;
    req_wdata = 32'h55667788;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_req && mem_addr == 32'h30C) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid_reached_acc1", found, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_req", mem_req, 1'b0);
    check("rst_mid_mem_wen", 32'(mem_wen), 32'h0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_ready_low", req_ready, 1'b0);
    exp_txn.delete();
    exp_res.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_no_done", done, 1'b0);
    check("rst_mid_ready_high", req_ready, 1'b1);
    check("rst_mid_first_kept", rd_word(32'h308), 32'h77880000);
    check("rst_mid_second_none", rd_word(32'h30C), 32'h0);
    do_req(1'b0, 3'b100, 32'h308, 32'h0, 0, 2, "ld_after_reset");
    check("ld_after_reset_lit", last_rdata, 32'h77880000);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
